// File: rtl/bp_update_sched.sv
// Branch-predictor update scheduler: tracks in-flight predicted branches and
// issues PHT/GHR update strobes and misprediction flushes when branches resolve.
// Latency: 1 cycle from pop to update strobe; stalls fetch while the queue is full.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   pred_valid/addr/ghr/taken - predicted branch from fetch (pushed into queue)
//   resolve_valid/taken - execute resolves the oldest in-flight branch (pop)
//   fetch_stall         - queue full, fetch must hold its branch
//   update_signal, actual_outcome, InstrAddr_E, ghr_E - registered update bundle
//   flush, ghr_restore  - one-cycle misprediction recovery
//   mispredict_cnt      - saturating misprediction counter
//   underflow_err       - sticky: resolve seen with an empty queue
module bp_update_sched #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pred_valid,
    input  logic [4:0] pred_addr,
    input  logic [4:0] pred_ghr,
    input  logic       pred_taken,
    input  logic       resolve_valid,
    input  logic       resolve_taken,
    output logic       fetch_stall,
    output logic       update_signal,
    output logic       actual_outcome,
    output logic [4:0] InstrAddr_E,
    output logic [4:0] ghr_E,
    output logic       flush,
    output logic [4:0] ghr_restore,
    output logic [7:0] mispredict_cnt,
    output logic       underflow_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [AW:0]   head_q, head_d;
    logic [AW:0]   tail_q, tail_d;
    logic          update_q, update_d;
    logic          outcome_q, outcome_d;
    logic [4:0]    addr_e_q, addr_e_d;
    logic [4:0]    ghr_e_q, ghr_e_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          underflow_q, underflow_d;

    // Entry storage is not reset: pointers alone define validity.
    logic [4:0]       addr_mem  [DEPTH];
    logic [4:0]       ghr_mem   [DEPTH];
    logic [DEPTH-1:0] taken_mem;

    // ------------------------------------------------------------------
    // Queue status and per-cycle events
    // ------------------------------------------------------------------
    logic          in_run;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          mispredict;
    logic          underflow_evt;
    logic [AW-1:0] head_idx;
    logic [AW-1:0] tail_idx;

    assign head_idx = head_q[AW-1:0];
    assign tail_idx = tail_q[AW-1:0];
    assign in_run   = (state_q == RUN);
    assign empty    = (head_q == tail_q);
    // Same slot, opposite wrap bits: writer has lapped the reader.
    assign full     = (head_idx == tail_idx) && (head_q[AW] != tail_q[AW]);

    assign pop           = in_run && resolve_valid && !empty;
    assign mispredict    = pop && (taken_mem[head_idx] != resolve_taken);
    assign underflow_evt = in_run && resolve_valid && empty;
    // A pop frees a slot this cycle, so a full queue can still accept a push.
    // Anything fetched alongside a mispredicting pop is on the wrong path.
    assign push          = in_run && pred_valid && (!full || pop) && !mispredict;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        update_d    = 1'b0;
        outcome_d   = outcome_q;
        addr_e_d    = addr_e_q;
        ghr_e_d     = ghr_e_q;
        cnt_d       = cnt_q;
        underflow_d = underflow_q | underflow_evt;

        case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Pointer update: a mispredict discards every younger entry, and the
        // queue stays empty for the whole recovery cycle.
        if (!in_run || mispredict) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            if (push) begin
                tail_d = tail_q + PTR_ONE;
            end
        end

        // Update bundle is registered; data fields hold between strobes so
        // the recovery cycle can still form ghr_restore from them.
        if (pop) begin
            update_d  = 1'b1;
            outcome_d = resolve_taken;
            addr_e_d  = addr_mem[head_idx];
            ghr_e_d   = ghr_mem[head_idx];
        end

        if (mispredict && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            head_q      <= '0;
            tail_q      <= '0;
            update_q    <= 1'b0;
            outcome_q   <= 1'b0;
            addr_e_q    <= '0;
            ghr_e_q     <= '0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            update_q    <= update_d;
            outcome_q   <= outcome_d;
            addr_e_q    <= addr_e_d;
            ghr_e_q     <= ghr_e_d;
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_idx]  <= pred_addr;
            ghr_mem[tail_idx]   <= pred_ghr;
            taken_mem[tail_idx] <= pred_taken;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fetch_stall    = full;
    assign update_signal  = update_q;
    assign actual_outcome = outcome_q;
    assign InstrAddr_E    = addr_e_q;
    assign ghr_E          = ghr_e_q;
    assign flush          = (state_q == RECOVER);
    // Corrected history: drop the oldest bit, shift in the real outcome.
    assign ghr_restore    = (state_q == RECOVER) ? {ghr_e_q[3:0], outcome_q} : 5'd0;
    assign mispredict_cnt = cnt_q;
    assign underflow_err  = underflow_q;

endmodule

// File: doc/bp_update_sched.md
BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, number of in-flight branch entries (power of two, 2..8).
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pred_valid  input  1  fetch stage presents a predicted branch this cycle.
REQ-005 pred_addr  input  5  InstrAddr_F of the predicted branch.
REQ-006 pred_ghr  input  5  GHR value used for that prediction.
REQ-007 pred_taken  input  1  predictor output for that branch.
REQ-008 resolve_valid  input  1  execute stage resolves the oldest in-flight branch.
REQ-009 resolve_taken  input  1  actual outcome of the resolved branch.
REQ-010 fetch_stall  output  1  queue full; fetch must hold its branch.
REQ-011 update_signal  output  1  one-cycle PHT/GHR update strobe.
REQ-012 actual_outcome  output  1  outcome accompanying update_signal.
REQ-013 InstrAddr_E  output  5  address accompanying update_signal.
REQ-014 ghr_E  output  5  history accompanying update_signal.
REQ-015 flush  output  1  one-cycle misprediction flush to the pipeline.
REQ-016 ghr_restore  output  5  corrected history {ghr_E[3:0], actual_outcome}, valid while flush=1.
REQ-017 mispredict_cnt  output  8  saturating misprediction count.
REQ-018 underflow_err  output  1  sticky: resolve arrived with queue empty.

Function
REQ-019 Queue: circular FIFO of DEPTH entries {addr, ghr, taken}, head/tail pointers with one extra wrap bit; full when pointers equal except wrap bit, empty when equal.
REQ-020 fetch_stall SHALL equal full, combinationally.
REQ-021 Push: in RUN, pred_valid AND (not full OR pop this cycle) writes the entry at tail and advances tail; pred_valid while full without a pop is dropped (fetch must hold).
REQ-022 Pop: in RUN, resolve_valid with queue non-empty pops the head; resolve_valid with queue empty sets underflow_err and changes nothing else.
REQ-023 On a pop, the next cycle SHALL present update_signal=1, actual_outcome=resolve_taken, InstrAddr_E/ghr_E = head entry fields (1-cycle registered latency); otherwise update_signal=0 and data outputs hold.
REQ-024 Mispredict = popped head.taken != resolve_taken.
REQ-025 FSM states RUN, RECOVER; reset enters RUN.
REQ-026 RUN -> RECOVER on a pop with mispredict; RECOVER -> RUN unconditionally after one cycle.
REQ-027 In RECOVER: flush=1, ghr_restore valid, head=tail=0 (all younger entries discarded), pred_valid and resolve_valid ignored, update_signal from the mispredicted pop still presented this same cycle.
REQ-028 A push coinciding with a mispredicting pop SHALL be discarded (wrong path).
REQ-029 A correct pop coinciding with a push while full SHALL succeed for both; occupancy unchanged.
REQ-030 mispredict_cnt increments by 1 on each RUN->RECOVER transition, saturating at 255.
REQ-031 flush=0 and ghr_restore=0 in RUN.

Reset
REQ-032 Reset asserted at any time, including mid-RECOVER, SHALL immediately force: state RUN, queue empty, fetch_stall=0, update_signal=0, actual_outcome=0, InstrAddr_E=0, ghr_E=0, flush=0, ghr_restore=0, mispredict_cnt=0, underflow_err=0.
REQ-033 Queue entry storage need not be cleared by reset.

Verification
REQ-034 Push addr 3/ghr 5/taken 1, then resolve_taken=1 -> next cycle update_signal=1, InstrAddr_E=3, ghr_E=5, actual_outcome=1, flush=0.
REQ-035 Push 4 entries (DEPTH=4) -> fetch_stall=1; 5th pred_valid dropped; simultaneous correct resolve + push -> occupancy stays 4, order preserved.
REQ-036 Push 3 entries, first taken=0, resolve_taken=1 with a push same cycle -> next cycle flush=1, ghr_restore={ghr[3:0],1}, mispredict_cnt=1; following cycle queue empty, fetch_stall=0.
REQ-037 resolve_valid with empty queue -> underflow_err=1 and stays 1, no update_signal.
REQ-038 256 mispredictions -> mispredict_cnt=255; assert reset during RECOVER -> all outputs 0 asynchronously, state RUN.
